// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses PLL reset, waits for a stable lock and only then releases sys_rst.
// Optional status counters (relock_cnt, timeout_cnt) are built when PLL_SUP_STATUS_EN is defined.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock_in,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       timeout,
`ifdef PLL_SUP_STATUS_EN
  output logic [7:0] relock_cnt,
  output logic [7:0] timeout_cnt,
`endif
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    RUN       = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_meta_q, lock_s_q;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             timeout_q, timeout_d;
  logic             cnt_clear;

  // lock_in is asynchronous to clk; only lock_s_q is allowed into the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lock_in;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    cnt_clear = 1'b0;
    if (restart) begin
      state_d   = PLL_RST;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // A lock seen on the final timeout cycle still wins over the retry.
          if (lock_s_q) begin
            state_d = QUALIFY;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = PLL_RST;
            timeout_d = 1'b1;
          end
        end
        QUALIFY: begin
          if (!lock_s_q)                 state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = RUN;
        end
        RUN: begin
          if (!lock_s_q) state_d = PLL_RST;
        end
        default: state_d = PLL_RST;
      endcase
    end
    if (state_d != state_q) cnt_clear = 1'b1;
    cnt_d = cnt_clear ? '0 : cnt_q + CNT_W'(1);
    // Outputs registered from next state so they change on the same edge as state.
    pll_reset_d = (state_d == PLL_RST);
    sys_rst_d   = (state_d != RUN);
    ready_d     = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign timeout   = timeout_q;
  assign state_o   = state_q;

`ifdef PLL_SUP_STATUS_EN
  logic [7:0] relock_cnt_q, relock_cnt_d;
  logic [7:0] timeout_cnt_q, timeout_cnt_d;
  logic       relock_ev;

  // A restart out of RUN is deliberate, not a loss of lock.
  assign relock_ev = (state_q == RUN) && (state_d == PLL_RST) && !restart;

  always_comb begin
    relock_cnt_d  = relock_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    if (relock_ev && (relock_cnt_q != 8'hff))  relock_cnt_d  = relock_cnt_q + 8'd1;
    if (timeout_d && (timeout_cnt_q != 8'hff)) timeout_cnt_d = timeout_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      relock_cnt_q  <= 8'd0;
      timeout_cnt_q <= 8'd0;
    end else begin
      relock_cnt_q  <= relock_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign relock_cnt  = relock_cnt_q;
  assign timeout_cnt = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
// Status counter checks are included when PLL_SUP_STATUS_EN is defined.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst;
  logic       lock_in;
  logic       restart;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic       timeout;
  logic [2:0] state_o;
`ifdef PLL_SUP_STATUS_EN
  logic [7:0] relock_cnt;
  logic [7:0] timeout_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pll_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock_in    (lock_in),
    .restart    (restart),
    .pll_reset  (pll_reset),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .timeout    (timeout),
`ifdef PLL_SUP_STATUS_EN
    .relock_cnt (relock_cnt),
    .timeout_cnt(timeout_cnt),
`endif
    .state_o    (state_o)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers: advance n clock edges, land 1 time unit after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_o(input string tag, input logic [2:0] st, input logic pr,
                          input logic sr, input logic rd, input logic to);
    chk({tag, ".state"},     {5'd0, state_o},   {5'd0, st});
    chk({tag, ".pll_reset"}, {7'd0, pll_reset}, {7'd0, pr});
    chk({tag, ".sys_rst"},   {7'd0, sys_rst},   {7'd0, sr});
    chk({tag, ".ready"},     {7'd0, ready},     {7'd0, rd});
    chk({tag, ".timeout"},   {7'd0, timeout},   {7'd0, to});
  endtask

  initial begin
    rst     = 1'b1;
    lock_in = 1'b0;
    restart = 1'b0;
    tick(3);
    expect_o("reset", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PLL_SUP_STATUS_EN
    chk("reset.relock_cnt", relock_cnt, 8'd0);
    chk("reset.timeout_cnt", timeout_cnt, 8'd0);
`endif
    rst = 1'b0;

    // Bring-up: 4-cycle pll_reset, lock 5 cycles later, sync + detect + 8 qualify cycles
    tick(3);  expect_o("t1_prst_hold",   3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t1_wait_enter",  3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(5);
    lock_in = 1'b1;
    tick(2);  expect_o("t1_sync_delay",  3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t1_qualify",     3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(7);  expect_o("t1_qualify_end", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t1_run",         3'd3, 1'b0, 1'b0, 1'b1, 1'b0);

    // Loss of lock in RUN
    tick(2);
    lock_in = 1'b0;
    tick(2);  expect_o("t4_sync_delay",  3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);  expect_o("t4_lost",        3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PLL_SUP_STATUS_EN
    chk("t4.relock_cnt", relock_cnt, 8'd1);
`endif
    tick(3);  expect_o("t4_prst_hold",   3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t4_wait",        3'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Lock never arrives: timeout after 20 cycles, retry period 24 cycles
    tick(19); expect_o("t2_before_to",   3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t2_timeout",     3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1);  expect_o("t2_pulse_end",   3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(3);  expect_o("t2_rewait",      3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(19); expect_o("t2_before_to2",  3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t2_timeout2",    3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef PLL_SUP_STATUS_EN
    chk("t2.timeout_cnt", timeout_cnt, 8'd2);
`endif
    tick(4);  expect_o("t3_wait",        3'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // One-cycle lock glitch at qualify cnt=5 -> back to WAIT_LOCK, full requalify
    lock_in = 1'b1;
    tick(3);  expect_o("t3_qualify",     3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(3);
    lock_in = 1'b0;
    tick(1);
    lock_in = 1'b1;
    tick(1);  expect_o("t3_cnt5",        3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t3_back_wait",   3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t3_requalify",   3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(7);  expect_o("t3_requal_end",  3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t3_run",         3'd3, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart pulse in RUN
    tick(2);
    restart = 1'b1;
    lock_in = 1'b0;
    tick(1);
    restart = 1'b0;
    expect_o("t5_restart_run", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PLL_SUP_STATUS_EN
    chk("t5.relock_cnt", relock_cnt, 8'd1);
`endif
    tick(3);  expect_o("t5_prst_hold",   3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t5_wait",        3'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Restart held two cycles in WAIT_LOCK keeps cnt at 0
    restart = 1'b1;
    tick(1);  expect_o("t5_restart_wait", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t5_restart_held", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    restart = 1'b0;
    tick(3);  expect_o("t5_held_prst",   3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t5_held_wait",   3'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Restart on the timeout cycle: no timeout pulse, full 4-cycle pll_reset
    tick(19);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    expect_o("t5_restart_to",  3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t5_no_pulse",    3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(2);  expect_o("t5_to_prst",     3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t5_to_wait",     3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PLL_SUP_STATUS_EN
    chk("t5.timeout_cnt", timeout_cnt, 8'd2);
`endif

    // Async reset between edges in QUALIFY
    lock_in = 1'b1;
    tick(3);  expect_o("t6_qualify",     3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2);
    #3;
    rst = 1'b1;
    #1;
    expect_o("t6_async_rst",   3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PLL_SUP_STATUS_EN
    chk("t6.relock_cnt", relock_cnt, 8'd0);
    chk("t6.timeout_cnt", timeout_cnt, 8'd0);
`endif
    tick(1);  expect_o("t6_rst_held",    3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick(4);  expect_o("t6_wait",        3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t6_qualify2",    3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(7);  expect_o("t6_qual_end",    3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);  expect_o("t6_run",         3'd3, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PLL_SUP_STATUS_EN
    // 300 consecutive timeouts saturate timeout_cnt
    restart = 1'b1;
    lock_in = 1'b0;
    tick(1);
    restart = 1'b0;
    tick(24 * 300 + 10);
    chk("t6.timeout_sat", timeout_cnt, 8'd255);
    chk("t6.relock_keep", relock_cnt, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
